// File: rtl/ws2811_pkg.sv
// Shared types and default 50 MHz timing for the WS2811 strip controller.
package ws2811_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_LATCH
  } state_e;

  typedef logic [23:0] grb_t;

  localparam int unsigned DEF_BIT_CYCLES   = 63;
  localparam int unsigned DEF_T0H_CYCLES   = 20;
  localparam int unsigned DEF_T1H_CYCLES   = 40;
  localparam int unsigned DEF_LATCH_CYCLES = 3000;
  localparam grb_t        DEF_DOT_COLOR    = 24'h00FF00;

  // Running-dot pattern: only the LED at the dot position carries the colour.
  function automatic logic pattern_bit(input logic [7:0] led, input logic [7:0] dot,
                                       input logic [4:0] idx, input grb_t color);
    return (led == dot) ? color[idx] : 1'b0;
  endfunction

endpackage

// File: rtl/ws2811_bit_encoder.sv
// Turns one data bit into a BIT_CYCLES-long NRZ high/low pulse on a registered output.
module ws2811_bit_encoder
  import ws2811_pkg::*;
#(
  parameter int unsigned BIT_CYCLES = DEF_BIT_CYCLES,
  parameter int unsigned T0H_CYCLES = DEF_T0H_CYCLES,
  parameter int unsigned T1H_CYCLES = DEF_T1H_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic bit_value,
  output logic serial_bit,
  output logic done
);

  localparam int unsigned CW = $clog2(BIT_CYCLES);
  localparam logic [CW-1:0] CNT_TOP = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] T0_THR  = CW'(BIT_CYCLES - 1 - T0H_CYCLES);
  localparam logic [CW-1:0] T1_THR  = CW'(BIT_CYCLES - 1 - T1H_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          val_q, val_d;
  logic          ser_q, ser_d;

  // done marks the final cycle of the bit so the next start can follow with no gap.
  assign done       = busy_q && (cnt_q == '0);
  assign serial_bit = ser_q;

  always_comb begin
    cnt_d  = cnt_q;
    busy_d = busy_q;
    val_d  = val_q;
    ser_d  = ser_q;
    if (start) begin
      cnt_d  = CNT_TOP;
      busy_d = 1'b1;
      val_d  = bit_value;
      ser_d  = 1'b1;
    end else if (busy_q) begin
      if (cnt_q == '0) begin
        busy_d = 1'b0;
        ser_d  = 1'b0;
      end else begin
        cnt_d = cnt_q - CW'(1);
        ser_d = cnt_d > (val_q ? T1_THR : T0_THR);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
      val_q  <= 1'b0;
      ser_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      val_q  <= val_d;
      ser_q  <= ser_d;
    end
  end

endmodule

// File: rtl/ws2811_array_controller.sv
// Frame sequencer for a WS2811 strip: running-dot pattern, back-to-back frames with latch gaps.
// state  | meaning
// IDLE   | line low, waiting for enable
// SEND   | shifting 24-bit GRB words for LEDs 0..n_leds-1
// LATCH  | line low for LATCH_CYCLES, then advance dot and restart or idle
module ws2811_array_controller
  import ws2811_pkg::*;
#(
  parameter int unsigned BIT_CYCLES   = DEF_BIT_CYCLES,
  parameter int unsigned T0H_CYCLES   = DEF_T0H_CYCLES,
  parameter int unsigned T1H_CYCLES   = DEF_T1H_CYCLES,
  parameter int unsigned LATCH_CYCLES = DEF_LATCH_CYCLES,
  parameter grb_t        DOT_COLOR    = DEF_DOT_COLOR
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] led_count,
  input  logic       enable,
  output logic       serial
);

  localparam int unsigned LW = $clog2(LATCH_CYCLES);
  localparam logic [LW-1:0] LATCH_TOP = LW'(LATCH_CYCLES - 1);

  state_e        state_q, state_d;
  logic [7:0]    n_leds_q, n_leds_d;
  logic [7:0]    led_idx_q, led_idx_d;
  logic [4:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    dot_q, dot_d;
  logic [LW-1:0] latch_q, latch_d;
  logic          kick_q, kick_d;
  logic [7:0]    dot_adv;
  logic          enc_start, enc_bit, enc_done;

  ws2811_bit_encoder #(
    .BIT_CYCLES (BIT_CYCLES),
    .T0H_CYCLES (T0H_CYCLES),
    .T1H_CYCLES (T1H_CYCLES)
  ) u_enc (
    .clock      (clock),
    .reset      (reset),
    .start      (enc_start),
    .bit_value  (enc_bit),
    .serial_bit (serial),
    .done       (enc_done)
  );

  assign dot_adv = ((n_leds_q == 8'd0) || (dot_q + 8'd1 == n_leds_q)) ? 8'd0 : dot_q + 8'd1;

  always_comb begin
    state_d   = state_q;
    n_leds_d  = n_leds_q;
    led_idx_d = led_idx_q;
    bit_idx_d = bit_idx_q;
    dot_d     = dot_q;
    latch_d   = latch_q;
    kick_d    = kick_q;
    enc_start = 1'b0;
    enc_bit   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          n_leds_d  = led_count;
          led_idx_d = 8'd0;
          bit_idx_d = 5'd23;
          dot_d     = (dot_q >= led_count) ? 8'd0 : dot_q;
          if (led_count == 8'd0) begin
            state_d = ST_LATCH;
            latch_d = LATCH_TOP;
          end else begin
            state_d = ST_SEND;
            kick_d  = 1'b1;
          end
        end
      end
      ST_SEND: begin
        if (kick_q) begin
          kick_d    = 1'b0;
          enc_start = 1'b1;
          enc_bit   = pattern_bit(led_idx_q, dot_q, bit_idx_q, DOT_COLOR);
        end else if (enc_done) begin
          if ((bit_idx_q == 5'd0) && (led_idx_q == n_leds_q - 8'd1)) begin
            state_d = ST_LATCH;
            latch_d = LATCH_TOP;
          end else begin
            if (bit_idx_q == 5'd0) begin
              led_idx_d = led_idx_q + 8'd1;
              bit_idx_d = 5'd23;
            end else begin
              bit_idx_d = bit_idx_q - 5'd1;
            end
            enc_start = 1'b1;
            enc_bit   = pattern_bit(led_idx_d, dot_q, bit_idx_d, DOT_COLOR);
          end
        end
      end
      ST_LATCH: begin
        if (latch_q != '0) begin
          latch_d = latch_q - LW'(1);
        end else if (enable) begin
          // Restart on the same edge so frames repeat with no extra cycle.
          n_leds_d  = led_count;
          led_idx_d = 8'd0;
          bit_idx_d = 5'd23;
          dot_d     = (dot_adv >= led_count) ? 8'd0 : dot_adv;
          if (led_count == 8'd0) begin
            latch_d = LATCH_TOP;
          end else begin
            state_d   = ST_SEND;
            enc_start = 1'b1;
            enc_bit   = pattern_bit(8'd0, dot_d, 5'd23, DOT_COLOR);
          end
        end else begin
          dot_d   = dot_adv;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      n_leds_q  <= 8'd0;
      led_idx_q <= 8'd0;
      bit_idx_q <= 5'd0;
      dot_q     <= 8'd0;
      latch_q   <= '0;
      kick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_leds_q  <= n_leds_d;
      led_idx_q <= led_idx_d;
      bit_idx_q <= bit_idx_d;
      dot_q     <= dot_d;
      latch_q   <= latch_d;
      kick_q    <= kick_d;
    end
  end

endmodule

// File: tb/tb_ws2811_array_controller.sv
// Directed bench for ws2811_array_controller: decodes the serial line bit by bit and checks timing.
module tb_ws2811_array_controller;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] led_count = 8'd0;
  logic       serial;
  logic [23:0] dot_word = 24'h00FF00;

  int checks = 0;
  int failures = 0;

  ws2811_array_controller dut (
    .clock     (clock),
    .reset     (reset),
    .led_count (led_count),
    .enable    (enable),
    .serial    (serial)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input int cycles, output int highs);
    @(negedge clock);
    reset = 1'b1;
    highs = 0;
    repeat (cycles) begin
      @(negedge clock);
      if (serial !== 1'b0) highs++;
    end
    reset = 1'b0;
  endtask

  // Counts low samples on following negedges until the line goes high.
  task automatic wait_rise(input int budget, output int lows);
    lows = 0;
    while (lows < budget) begin
      @(negedge clock);
      if (serial === 1'b1) break;
      lows++;
    end
  endtask

  // Counts low samples starting with the current one.
  task automatic count_low(input int budget, output int lows);
    lows = 0;
    while (lows < budget && serial !== 1'b1) begin
      lows++;
      @(negedge clock);
    end
  endtask

  // Reads one 63-cycle bit starting at the current sample; leaves us on the next bit's first sample.
  task automatic get_bit(output int hi, output int stray);
    hi = 0;
    stray = 0;
    for (int i = 0; i < 63; i++) begin
      if (serial === 1'b1) begin
        if (hi == i) hi++;
        else stray++;
      end
      @(negedge clock);
    end
  endtask

  task automatic get_leds(input string tag, input int first, input int cnt, input int dot);
    int hi, stray, bad, lit, exp_lit;
    logic [23:0] w;
    logic e;
    bad = 0;
    lit = -1;
    for (int led = first; led < first + cnt; led++) begin
      w = '0;
      for (int b = 23; b >= 0; b--) begin
        get_bit(hi, stray);
        e = (led == dot) ? dot_word[b] : 1'b0;
        if (stray != 0 || hi != (e ? 40 : 20)) bad++;
        w[b] = (hi == 40);
      end
      if (w == dot_word && lit < 0) lit = led;
    end
    exp_lit = (dot >= first && dot < first + cnt) ? dot : -1;
    chk({tag, " bad_bits"}, bad, 0);
    chk({tag, " lit_led"}, lit, exp_lit);
  endtask

  initial begin
    int v, lows;

    // Reset hold with enable high, then first frame and dot walk on 3 LEDs.
    led_count = 8'd3;
    enable = 1'b1;
    do_reset(100, v);
    chk("reset_hold_highs", v, 0);
    wait_rise(10, lows);
    chk("start_latency", lows, 1);
    get_leds("f0", 0, 3, 0);
    count_low(4000, lows);
    chk("f0 latch", lows, 3000);
    get_leds("f1", 0, 3, 1);
    count_low(4000, lows);
    chk("f1 latch", lows, 3000);
    get_leds("f2", 0, 3, 2);
    count_low(4000, lows);
    chk("f2 latch", lows, 3000);
    get_leds("f3", 0, 1, 0);

    // Longer strip: full frame, latch, then dot on LED 1.
    led_count = 8'd8;
    do_reset(4, v);
    chk("long reset_highs", v, 0);
    wait_rise(10, lows);
    chk("long latency", lows, 1);
    get_leds("long0", 0, 8, 0);
    count_low(4000, lows);
    chk("long latch", lows, 3000);
    get_leds("long1", 0, 2, 1);

    // Enable dropped during LED 1: frame and latch finish, then idle.
    led_count = 8'd3;
    do_reset(4, v);
    wait_rise(10, lows);
    chk("drop latency", lows, 1);
    get_leds("drop_a", 0, 1, 0);
    enable = 1'b0;
    get_leds("drop_b", 1, 2, 0);
    count_low(5000, lows);
    chk("drop idle_low", lows, 5000);
    enable = 1'b1;
    wait_rise(10, lows);
    chk("drop restart_latency", lows, 1);
    get_leds("drop_c", 0, 2, 1);

    // Zero-length strip never drives the line high.
    led_count = 8'd0;
    do_reset(4, v);
    count_low(4000, lows);
    chk("zero no_rise", lows, 4000);

    // Strip shrinks 3 -> 1 mid-frame: current frame unaffected, next frame is 1 LED with dot 0.
    led_count = 8'd3;
    do_reset(4, v);
    wait_rise(10, lows);
    chk("shrink latency", lows, 1);
    get_leds("shrink_a", 0, 1, 0);
    led_count = 8'd1;
    get_leds("shrink_b", 1, 2, 0);
    count_low(4000, lows);
    chk("shrink latch0", lows, 3000);
    get_leds("shrink_c", 0, 1, 0);
    count_low(4000, lows);
    chk("shrink latch1", lows, 3000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
